sp_ram_burst_reader: RTL and testbench

Read-side burst controller that sits directly upstream of the single-port RAM wrapper (xpm_sp_ram) and drives its port A. It accepts a (start address, length) command and issues one read per cycle to the RAM. It tracks the RAM's fixed read latency and returns the words, in address order, as a valid/ready stream with a last flag. A credit-limited output FIFO guarantees no returned word is ever dropped under downstream backpressure.

---
 rtl/sp_ram_burst_reader.sv | 208 ++++++++++++++++++++
 tb/tb_sp_ram_burst_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_burst_reader.sv
// Burst read controller for a single-port RAM with fixed read latency.
// Returns words in address order on a valid/ready stream with credit-limited FIFO.
module sp_ram_burst_reader #(
    parameter int AW           = 3,
    parameter int DW           = 4,
    parameter int READ_LATENCY = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clka,
    input  logic          rsta_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_len,
    output logic [AW-1:0] ram_addra,
    output logic          ram_ena,
    output logic          ram_wea,
    output logic          ram_regcea,
    input  logic [DW-1:0] ram_douta,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CRED_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_addr;
    logic [AW:0]     r_rem;
    logic [CW-1:0]   r_credits;
    logic [CW-1:0]   w_cred_pop;

    logic            w_issue;
    logic            w_issue_last;
    logic [AW-1:0]   w_issue_addr;
    logic [AW:0]     w_issue_rem;
    logic            w_cmd_ready;

    logic            r_ram_ena;
    logic            r_ram_last;
    logic [AW-1:0]   r_ram_addra;

    logic [READ_LATENCY-1:0] r_pv;
    logic [READ_LATENCY-1:0] r_pl;

    logic [DW-1:0]   r_fd [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fl;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_m_valid;

    assign w_m_valid  = (r_count != '0);
    assign w_pop      = w_m_valid & m_ready;
    assign w_push     = r_pv[READ_LATENCY-1];
    assign w_cred_pop = r_credits + CW'(w_pop);

    // Next-state and issue decision; the first read issues on the command handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        w_issue_addr = r_addr;
        w_issue_rem  = r_rem;
        w_cmd_ready  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid && (cmd_len != '0)) begin
                    w_issue      = 1'b1;
                    w_issue_addr = cmd_addr;
                    w_issue_rem  = cmd_len;
                    w_issue_last = (cmd_len == LEN_ONE);
                    w_state_nxt  = w_issue_last ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if ((r_rem != '0) && (r_credits != '0)) begin
                    w_issue      = 1'b1;
                    w_issue_last = (r_rem == LEN_ONE);
                    if (w_issue_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_cred_pop == CRED_FULL) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, current address and remaining word count.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_addr <= w_issue_addr + ADDR_ONE;
                r_rem  <= w_issue_rem - LEN_ONE;
            end
        end
    end

    // Registered RAM port A request.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_ram_ena   <= 1'b0;
            r_ram_last  <= 1'b0;
            r_ram_addra <= '0;
        end else begin
            r_ram_ena  <= w_issue;
            r_ram_last <= w_issue & w_issue_last;
            if (w_issue) begin
                r_ram_addra <= w_issue_addr;
            end
        end
    end

    // Credits track free FIFO slots not yet claimed by in-flight reads.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_credits <= CRED_FULL;
        end else if (w_issue && !w_pop) begin
            r_credits <= r_credits - CNT_ONE;
        end else if (w_pop && !w_issue) begin
            r_credits <= r_credits + CNT_ONE;
        end
    end

    // Valid/last shift register aligned with the RAM read latency.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_pv <= '0;
            r_pl <= '0;
        end else begin
            r_pv[0] <= r_ram_ena;
            r_pl[0] <= r_ram_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pl[i] <= r_pl[i-1];
            end
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fd[i] <= '0;
            end
            r_fl    <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fd[r_wptr] <= ram_douta;
                r_fl[r_wptr] <= r_pl[READ_LATENCY-1];
                r_wptr       <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign ram_ena    = r_ram_ena;
    assign ram_addra  = r_ram_addra;
    assign ram_wea    = 1'b0;
    assign ram_regcea = 1'b1;
    assign m_valid    = w_m_valid;
    assign m_data     = r_fd[r_rptr];
    assign m_last     = w_m_valid & r_fl[r_rptr];
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sp_ram_burst_reader.sv
// Directed bench for sp_ram_burst_reader with a latency-3 RAM model.
// Checks ordering, latency, wrap, backpressure, zero length and reset.
module tb_sp_ram_burst_reader;

    localparam int AW = 3;
    localparam int DW = 4;
    localparam int RL = 3;
    localparam int FD = 4;

    logic          clka = 1'b0;
    logic          rsta_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic [AW-1:0] ram_addra;
    logic          ram_ena;
    logic          ram_wea;
    logic          ram_regcea;
    logic [DW-1:0] ram_douta;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;

    int q_data[$];
    int q_last[$];
    int q_cyc[$];
    int e_addr[$];
    int e_cyc[$];
    int hs[$];

    logic [DW-1:0] mem [8];
    logic [DW-1:0] d1 = '0;
    logic [DW-1:0] d2 = '0;
    logic [DW-1:0] d3 = '0;

    always #5 clka = ~clka;

    always @(posedge clka) cyc = cyc + 1;

    // RAM model: data appears RL cycles after the enable cycle
    always @(posedge clka) begin
        if (ram_ena) d1 <= mem[ram_addra];
        d2 <= d1;
        d3 <= d2;
    end
    assign ram_douta = d3;

    sp_ram_burst_reader #(
        .AW(AW), .DW(DW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clka(clka), .rsta_n(rsta_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_addra(ram_addra), .ram_ena(ram_ena),
        .ram_wea(ram_wea), .ram_regcea(ram_regcea),
        .ram_douta(ram_douta),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy)
    );

    always @(negedge clka) begin
        if (m_valid && m_ready) begin
            q_data.push_back(int'(m_data));
            q_last.push_back(int'(m_last));
            q_cyc.push_back(cyc);
        end
        if (ram_ena) begin
            e_addr.push_back(int'(ram_addra));
            e_cyc.push_back(cyc);
        end
        if (cmd_valid && cmd_ready) hs.push_back(cyc);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clka);
        #1;
    endtask

    task automatic clr();
        q_data.delete(); q_last.delete(); q_cyc.delete();
        e_addr.delete(); e_cyc.delete(); hs.delete();
    endtask

    task automatic send_cmd(input int a, input int l);
        int k = 0;
        @(posedge clka);
        #1;
        cmd_addr = AW'(a);
        cmd_len = (AW+1)'(l);
        cmd_valid = 1'b1;
        do begin tick(); k++; end while (!cmd_ready && k < 100);
        check("cmd_accept", int'(cmd_ready), 1);
        @(posedge clka);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int k = 0;
        while (q_data.size() < n && k < 200) begin tick(); k++; end
        check(tag, q_data.size(), n);
    endtask

    initial begin
        int held;
        int k;
        int e1[4] = '{11, 12, 5, 6};
        int a2[4] = '{6, 7, 0, 1};
        int e6[4] = '{5, 6, 8, 9};
        for (int i = 0; i < 8; i++) mem[i] = DW'(i + 5);

        repeat (3) tick();
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_ram_ena", int'(ram_ena), 0);
        check("rst_ram_addra", int'(ram_addra), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wea", int'(ram_wea), 0);
        check("rst_regcea", int'(ram_regcea), 1);
        @(negedge clka);
        rsta_n = 1'b1;
        repeat (2) tick();

        // single burst
        clr();
        send_cmd(2, 3);
        wait_words("t1_count", 3);
        repeat (5) tick();
        check("t1_total", q_data.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_data%0d", i), q_data[i], 7 + i);
            check($sformatf("t1_last%0d", i), q_last[i], (i == 2) ? 1 : 0);
            check($sformatf("t1_addr%0d", i), e_addr[i], 2 + i);
        end
        check("t1_ena_lat", e_cyc[0] - hs[0], 1);
        check("t1_data_lat", q_cyc[0] - hs[0], RL + 2);
        check("t1_burst1", q_cyc[1] - q_cyc[0], 1);
        check("t1_burst2", q_cyc[2] - q_cyc[0], 2);

        // wrap
        clr();
        send_cmd(6, 4);
        wait_words("t2_count", 4);
        check("t2_busy_final", int'(busy), 1);
        tick();
        check("t2_busy_after", int'(busy), 0);
        repeat (4) tick();
        check("t2_total", q_data.size(), 4);
        check("t2_ena_total", e_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_addr%0d", i), e_addr[i], a2[i]);
            check($sformatf("t2_data%0d", i), q_data[i], e1[i]);
            check($sformatf("t2_last%0d", i), q_last[i], (i == 3) ? 1 : 0);
        end

        // backpressure
        clr();
        m_ready = 1'b0;
        send_cmd(0, 8);
        held = -1;
        repeat (9) begin
            tick();
            if (m_valid) begin
                if (held < 0) held = int'(m_data);
                else check("t3_stable", int'(m_data), held);
            end
        end
        check("t3_valid_stall", int'(m_valid), 1);
        check("t3_head", int'(m_data), 5);
        check("t3_last_stall", int'(m_last), 0);
        check("t3_ena_stall", e_addr.size(), 4);
        @(posedge clka);
        #1;
        m_ready = 1'b1;
        wait_words("t3_count", 8);
        repeat (6) tick();
        check("t3_total", q_data.size(), 8);
        check("t3_ena_total", e_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_data%0d", i), q_data[i], 5 + i);
            check($sformatf("t3_last%0d", i), q_last[i], (i == 7) ? 1 : 0);
        end

        // zero length
        clr();
        send_cmd(0, 0);
        tick();
        check("t4_cmd_ready", int'(cmd_ready), 1);
        check("t4_busy", int'(busy), 0);
        repeat (6) tick();
        check("t4_hs", hs.size(), 1);
        check("t4_ena", e_addr.size(), 0);
        check("t4_words", q_data.size(), 0);
        check("t4_m_valid", int'(m_valid), 0);

        // reset mid-burst
        clr();
        send_cmd(0, 8);
        k = 0;
        while (e_addr.size() < 3 && k < 50) begin tick(); k++; end
        check("t5_issue3", e_addr.size(), 3);
        repeat (2) @(posedge clka);
        #1;
        rsta_n = 1'b0;
        #1;
        check("t5_m_valid", int'(m_valid), 0);
        check("t5_credits", int'(dut.r_credits), FD);
        check("t5_busy", int'(busy), 0);
        check("t5_ram_ena", int'(ram_ena), 0);
        repeat (2) @(negedge clka);
        rsta_n = 1'b1;
        tick();
        clr();
        repeat (8) tick();
        check("t5_stale", q_data.size(), 0);
        send_cmd(1, 2);
        wait_words("t5_count", 2);
        repeat (6) tick();
        check("t5_total", q_data.size(), 2);
        check("t5_data0", q_data[0], 6);
        check("t5_data1", q_data[1], 7);
        check("t5_last0", q_last[0], 0);
        check("t5_last1", q_last[1], 1);

        // back-to-back commands
        clr();
        @(posedge clka);
        #1;
        cmd_addr = 3'd0;
        cmd_len = 4'd2;
        cmd_valid = 1'b1;
        k = 0;
        while (hs.size() < 1 && k < 50) begin tick(); k++; end
        @(posedge clka);
        #1;
        cmd_addr = 3'd3;
        k = 0;
        while (hs.size() < 2 && k < 50) begin tick(); k++; end
        @(posedge clka);
        #1;
        cmd_valid = 1'b0;
        wait_words("t6_count", 4);
        repeat (6) tick();
        check("t6_total", q_data.size(), 4);
        check("t6_hs", hs.size(), 2);
        check("t6_order", int'(hs[1] > q_cyc[1]), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_data%0d", i), q_data[i], e6[i]);
            check($sformatf("t6_last%0d", i), q_last[i], i % 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
